// File: rtl/rxll_pkg.sv
// rxll_pkg: shared FIFO word layout and read-scheduler state encoding.
package rxll_pkg;
  localparam int RXLL_SOF_BIT = 35;
  localparam int RXLL_EOF_BIT = 34;
  localparam int RXLL_ERR_BIT = 33;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_BURST, ST_DONE, ST_FLUSH} state_e;
endpackage

// File: rtl/rxll_rd_sched_if.sv
// rxll_rd_sched_if: DMA request/grant and data handshake between scheduler and DMA engine.
interface rxll_rd_sched_if;
  logic        dma_req;
  logic        dma_gnt;
  logic [31:0] dma_data;
  logic        dma_valid;
  logic        dma_ready;
  logic        dma_last;
  modport master (output dma_req, dma_data, dma_valid, dma_last, input dma_gnt, dma_ready);
  modport slave (input dma_req, dma_data, dma_valid, dma_last, output dma_gnt, dma_ready);
endinterface

// File: rtl/rxll_frame_acc.sv
// rxll_frame_acc: per-frame saturating word count and error OR with held result registers.
module rxll_frame_acc
  import rxll_pkg::*;
#(
  parameter int C_LEN_WIDTH = 16
) (
  input  logic                   rd_clk,
  input  logic                   rst,
  input  logic                   word_i,
  input  logic                   sof_i,
  input  logic                   err_i,
  input  logic                   force_err_i,
  input  logic                   load_i,
  input  logic                   clr_i,
  output logic [C_LEN_WIDTH-1:0] frame_len_o,
  output logic                   frame_err_o
);
  logic [C_LEN_WIDTH-1:0] len_q, len_d, frame_len_q;
  logic                   err_q, err_d, frame_err_q;
  always_comb begin
    len_d = len_q;
    err_d = err_q;
    if (word_i) begin
      len_d = sof_i ? C_LEN_WIDTH'(1) : (&len_q ? len_q : len_q + 1'b1);
      err_d = (sof_i ? 1'b0 : err_q) | err_i | force_err_i;
    end
  end
  // results are loaded with the next-state values so they are valid alongside frame_done
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      len_q       <= '0;
      err_q       <= 1'b0;
      frame_len_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      len_q <= clr_i ? '0 : len_d;
      err_q <= clr_i ? 1'b0 : err_d;
      if (load_i) begin
        frame_len_q <= len_d;
        frame_err_q <= err_d;
      end
    end
  end
  assign frame_len_o = frame_len_q;
  assign frame_err_o = frame_err_q;
endmodule

// File: rtl/rxll_rd_sched.sv
// rxll_rd_sched: drains the FWFT receive FIFO to the DMA port in granted bursts and reports per-frame status.
module rxll_rd_sched
  import rxll_pkg::*;
#(
  parameter int C_BURST     = 16,
  parameter int C_LEN_WIDTH = 16
) (
  input  logic                   rd_clk,
  input  logic                   rst,
  input  logic [35:0]            fifo_do,
  input  logic                   fifo_empty,
  input  logic                   fifo_almost_empty,
  input  logic                   fifo_eof_rdy,
  output logic                   fifo_rd_en,
  rxll_rd_sched_if.master        dma,
  input  logic                   abort,
  output logic                   frame_done,
  output logic [C_LEN_WIDTH-1:0] frame_len,
  output logic                   frame_err,
  output logic                   flush_busy
);
  localparam int BW = (C_BURST > 1) ? $clog2(C_BURST) : 1;
  state_e          state_q, state_d;
  logic [BW-1:0]   bcnt_q;
  logic            dma_req_q, frame_done_q, flush_busy_q;
  logic            eof, in_burst, in_flush, xfer, flush_pop, start, abort_ok, unused;
  assign eof        = fifo_do[RXLL_EOF_BIT];
  assign in_burst   = state_q == ST_BURST;
  assign in_flush   = state_q == ST_FLUSH;
  assign dma.dma_valid = in_burst && !fifo_empty;
  assign dma.dma_data  = fifo_do[31:0];
  assign dma.dma_last  = dma.dma_valid && (bcnt_q == BW'(C_BURST - 1) || eof);
  assign dma.dma_req   = dma_req_q;
  assign xfer       = dma.dma_valid && dma.dma_ready;
  assign flush_pop  = in_flush && !fifo_empty;
  assign fifo_rd_en = xfer || flush_pop;
  assign start      = !fifo_empty && (fifo_eof_rdy || !fifo_almost_empty);
  assign abort_ok   = abort && (state_q inside {ST_IDLE, ST_REQ, ST_BURST});
  assign unused     = fifo_do[32];
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = abort_ok ? ST_FLUSH : start ? ST_REQ : ST_IDLE;
      ST_REQ:   state_d = abort_ok ? ST_FLUSH : dma.dma_gnt ? ST_BURST : ST_REQ;
      ST_BURST: state_d = (xfer && eof) ? ST_DONE : abort_ok ? ST_FLUSH :
                          (xfer && dma.dma_last) ? ST_IDLE : ST_BURST;
      ST_FLUSH: state_d = (flush_pop && eof) ? ST_DONE : ST_FLUSH;
      default:  state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge rd_clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bcnt_q       <= '0;
      dma_req_q    <= 1'b0;
      frame_done_q <= 1'b0;
      flush_busy_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bcnt_q       <= (state_q == ST_REQ) ? '0 : xfer ? bcnt_q + 1'b1 : bcnt_q;
      dma_req_q    <= state_d == ST_REQ;
      frame_done_q <= state_d == ST_DONE;
      flush_busy_q <= state_d == ST_FLUSH;
    end
  end
  assign frame_done = frame_done_q;
  assign flush_busy = flush_busy_q;
  rxll_frame_acc #(.C_LEN_WIDTH(C_LEN_WIDTH)) u_acc (
    .rd_clk      (rd_clk),
    .rst         (rst),
    .word_i      (fifo_rd_en),
    .sof_i       (fifo_do[RXLL_SOF_BIT]),
    .err_i       (fifo_do[RXLL_ERR_BIT]),
    .force_err_i (flush_pop && eof),
    .load_i      (state_d == ST_DONE && state_q != ST_DONE),
    .clr_i       (state_q == ST_DONE),
    .frame_len_o (frame_len),
    .frame_err_o (frame_err)
  );
endmodule

// File: tb/tb_rxll_rd_sched.sv
// tb_rxll_rd_sched: FIFO/DMA models with a scoreboard monitor checking words and frame reports.
module tb_rxll_rd_sched;
  logic        rd_clk = 1'b0;
  logic        rst = 1'b1;
  logic [35:0] fifo_do;
  logic        fifo_empty, fifo_almost_empty, fifo_eof_rdy, fifo_rd_en;
  logic        abort, frame_done, frame_err, flush_busy;
  logic [15:0] frame_len;
  always #5 rd_clk = ~rd_clk;
  rxll_rd_sched_if dif ();
  rxll_rd_sched #(.C_BURST(16), .C_LEN_WIDTH(16)) dut (
    .rd_clk            (rd_clk),
    .rst               (rst),
    .fifo_do           (fifo_do),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_eof_rdy      (fifo_eof_rdy),
    .fifo_rd_en        (fifo_rd_en),
    .dma               (dif),
    .abort             (abort),
    .frame_done        (frame_done),
    .frame_len         (frame_len),
    .frame_err         (frame_err),
    .flush_busy        (flush_busy)
  );
  typedef struct {logic [31:0] data; logic last;} wexp_t;
  typedef struct {logic [15:0] len; logic err;} fexp_t;
  logic [35:0] fq[$];
  wexp_t       wq[$];
  fexp_t       fxq[$];
  int total = 0, bad = 0, done_cnt = 0, xfer_cnt = 0, flush_cnt = 0, req_rises = 0, req_cnt = 0;
  logic req_prev = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void upd();
    fifo_empty        = fq.size() == 0;
    fifo_do           = fifo_empty ? 36'd0 : fq[0];
    fifo_almost_empty = fq.size() < 256;
    fifo_eof_rdy      = 1'b0;
    foreach (fq[i]) if (fq[i][34]) fifo_eof_rdy = 1'b1;
  endfunction
  task automatic load_frame(input int id, input int n, input int err_idx, input int n_exp,
                            input logic [15:0] len, input logic err);
    logic [35:0] w;
    for (int i = 0; i < n; i++) begin
      w = {i == 0, i == n - 1, i == err_idx, 1'b0, 16'(id), 16'(i)};
      fq.push_back(w);
      if (i < n_exp) wq.push_back('{w[31:0], (i % 16 == 15) || (i == n - 1)});
    end
    fxq.push_back('{len, err});
    upd();
  endtask
  task automatic wait_done(input int target, input string name);
    int c = 0;
    while (done_cnt < target && c < 1000) begin
      @(posedge rd_clk);
      c++;
    end
    chk({name, "_done"}, done_cnt, target);
    chk({name, "_words_left"}, wq.size(), 0);
  endtask
  always @(posedge rd_clk) begin
    if (fifo_rd_en && !rst) begin
      #1;
      if (fq.size() > 0) void'(fq.pop_front());
      upd();
    end
  end
  always @(negedge rd_clk) begin
    req_cnt = dif.dma_req ? req_cnt + 1 : 0;
    dif.dma_gnt = dif.dma_req && req_cnt >= 2;
  end
  always @(negedge rd_clk) begin
    wexp_t we;
    fexp_t fe;
    if (!rst) begin
      if (dif.dma_req && !req_prev) req_rises++;
      req_prev = dif.dma_req;
      if (dif.dma_valid && !dif.dma_ready) chk("rd_en_hold", fifo_rd_en, 0);
      if (dif.dma_valid && dif.dma_ready) begin
        xfer_cnt++;
        chk("word_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          we = wq.pop_front();
          chk("data", dif.dma_data, we.data);
          chk("last", dif.dma_last, we.last);
        end
      end
      if (flush_busy) begin
        chk("flush_valid", dif.dma_valid, 0);
        if (fifo_rd_en) flush_cnt++;
      end
      if (frame_done) begin
        done_cnt++;
        chk("frame_expected", fxq.size() > 0, 1);
        if (fxq.size() > 0) begin
          fe = fxq.pop_front();
          chk("frame_len", frame_len, fe.len);
          chk("frame_err", frame_err, fe.err);
        end
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int c;
    abort = 1'b0;
    dif.dma_ready = 1'b1;
    upd();
    repeat (3) @(posedge rd_clk);
    #1 rst = 1'b0;
    @(negedge rd_clk);
    chk("rst_req", dif.dma_req, 0);
    chk("rst_valid", dif.dma_valid, 0);
    chk("rst_last", dif.dma_last, 0);
    chk("rst_rd_en", fifo_rd_en, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_len", frame_len, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_flush", flush_busy, 0);
    @(posedge rd_clk);
    #1 req_rises = 0;
    load_frame(1, 5, -1, 5, 16'd5, 1'b0);
    wait_done(1, "t1");
    chk("t1_bursts", req_rises, 1);
    #1 req_rises = 0;
    load_frame(2, 40, -1, 40, 16'd40, 1'b0);
    wait_done(2, "t2");
    chk("t2_bursts", req_rises, 3);
    #1 load_frame(3, 4, -1, 4, 16'd4, 1'b0);
    c = 0;
    while (done_cnt < 3 && c < 200) begin
      @(posedge rd_clk);
      #1 dif.dma_ready = ~dif.dma_ready;
      c++;
    end
    dif.dma_ready = 1'b1;
    wait_done(3, "t3");
    flush_cnt = 0;
    load_frame(4, 10, -1, 4, 16'd10, 1'b1);
    c = 0;
    do begin
      @(negedge rd_clk);
      c++;
    end while (!(dif.dma_valid && dif.dma_ready && dif.dma_data == {16'd4, 16'd3}) && c < 200);
    chk("t4_word3_seen", dif.dma_valid && dif.dma_ready, 1);
    @(posedge rd_clk);
    #1 dif.dma_ready = 1'b0;
    abort = 1'b1;
    @(posedge rd_clk);
    #1 abort = 1'b0;
    dif.dma_ready = 1'b1;
    @(negedge rd_clk);
    chk("t4_req_drop", dif.dma_req, 0);
    chk("t4_flush_busy", flush_busy, 1);
    wait_done(4, "t4");
    chk("t4_flushed", flush_cnt, 6);
    #1 load_frame(5, 6, 2, 6, 16'd6, 1'b1);
    wait_done(5, "t5");
    c = xfer_cnt;
    load_frame(6, 20, -1, 20, 16'd20, 1'b0);
    while (xfer_cnt < c + 3 && c < 100000) begin
      @(posedge rd_clk);
      if (xfer_cnt >= c + 3) break;
    end
    #1 rst = 1'b1;
    @(posedge rd_clk);
    #2 fq.delete();
    wq.delete();
    fxq.delete();
    upd();
    @(negedge rd_clk);
    chk("t6_req", dif.dma_req, 0);
    chk("t6_valid", dif.dma_valid, 0);
    chk("t6_last", dif.dma_last, 0);
    chk("t6_rd_en", fifo_rd_en, 0);
    chk("t6_done", frame_done, 0);
    chk("t6_len", frame_len, 0);
    chk("t6_flush", flush_busy, 0);
    @(posedge rd_clk);
    #1 rst = 1'b0;
    load_frame(7, 3, -1, 3, 16'd3, 1'b0);
    wait_done(6, "t7");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
